fetch_unit: RTL



---
 rtl/fetch_unit.sv | 76 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Program counter and instruction register stage in front of programMemory.
// Fetches sequentially, takes redirects from execute, honours stall, stops on HALT.
module fetch_unit #(
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 13,
  parameter int               OPC_W    = 3,
  parameter logic [OPC_W-1:0] HALT_OPC = 3'b111
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  // state  | meaning
  // RUN    | fetching; pc advances, redirects and stalls honoured
  // HALTED | HALT word captured; pc frozen until reset
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              is_halt;

  assign mem_addr = pc;
  assign is_halt  = (mem_data[INSTR_W-1 -: OPC_W] == HALT_OPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (jump_en) begin
            // Redirect wins over stall and over a HALT word on the bus.
            pc          <= jump_addr;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr       <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        HALTED: begin
          // The HALT instruction stays valid until the decoder consumes it.
          if (!stall) instr_valid <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
